// File: rtl/outpass_n_delay_config_pkg.sv
// Shared configuration-field layout for the per-channel output pass delay cells.
package outpass_n_delay_config_pkg;

  localparam int unsigned DELAY_OFS = 0;

  function automatic int unsigned ce_ofs(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned inv_ofs(input int unsigned dw);
    return dw + 1;
  endfunction

  function automatic int unsigned ch_cfg_w(input int unsigned dw);
    return dw + 2;
  endfunction

endpackage

// File: rtl/outpass_delay_chan.sv
// One output channel: CE-gated shift chain, clamped delay tap select, optional inversion.
module outpass_delay_chan
  import outpass_n_delay_config_pkg::*;
#(
  parameter int unsigned MAX_DEPTH = 3,
  parameter int unsigned DW        = 2
) (
  input  logic          UserCLK,
  input  logic          resetn,
  input  logic          I,
  input  logic          CE,
  input  logic [DW+1:0] cfg,
  output logic          O
);

  localparam int unsigned CE_OFS  = ce_ofs(DW);
  localparam int unsigned INV_OFS = inv_ofs(DW);

  logic [MAX_DEPTH-1:0] s_q;
  logic [MAX_DEPTH-1:0] s_d;
  logic [DW-1:0]        delay;
  logic [DW-1:0]        eff;
  logic                 adv;
  logic                 tap;

  assign delay = cfg[DELAY_OFS +: DW];
  assign adv   = cfg[CE_OFS] ? CE : 1'b1;
  assign eff   = (32'(delay) > MAX_DEPTH) ? DW'(MAX_DEPTH) : delay;

  // Chain shifts on every advancing edge regardless of the selected depth.
  always_comb begin
    s_d = s_q;
    if (adv) begin
      s_d[0] = I;
      for (int unsigned k = 1; k < MAX_DEPTH; k++) begin
        s_d[k] = s_q[k-1];
      end
    end
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  // Depth 0 is a straight combinational bypass of the input.
  always_comb begin
    tap = I;
    for (int unsigned k = 0; k < MAX_DEPTH; k++) begin
      if (eff == DW'(k + 1)) begin
        tap = s_q[k];
      end
    end
  end

  assign O = tap ^ cfg[INV_OFS];

endmodule

// File: rtl/outpass_n_delay_config.sv
// NUM_CH independent configurable-delay output pass channels driving external pins.
module outpass_n_delay_config
  import outpass_n_delay_config_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned MAX_DEPTH    = 3,
  parameter int unsigned DW           = 2,
  parameter int unsigned NoConfigBits = 16
) (
  input  logic                    UserCLK,
  input  logic                    resetn,
  input  logic [NUM_CH-1:0]       I,
  input  logic                    CE,
  output logic [NUM_CH-1:0]       O,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  localparam int unsigned CFG_W = ch_cfg_w(DW);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    outpass_delay_chan #(
      .MAX_DEPTH(MAX_DEPTH),
      .DW       (DW)
    ) u_chan (
      .UserCLK(UserCLK),
      .resetn (resetn),
      .I      (I[c]),
      .CE     (CE),
      .cfg    (ConfigBits[c*CFG_W +: CFG_W]),
      .O      (O[c])
    );
  end

endmodule

// File: tb/tb_outpass_n_delay_config.sv
// Self-checking bench: bypass table, hand-written delay/CE/clamp/reset sequences, randomized scoreboard.
module tb_outpass_n_delay_config;

  logic        clk;
  logic        rst_n;
  logic [15:0] cfg_a, cfg_b;
  logic [3:0]  i_a, i_b, o_a, o_b;
  logic        ce_a, ce_b, ce_c;
  logic [23:0] cfg_c;
  logic [7:0]  i_c, o_c;

  int errors = 0;
  int checks = 0;

  outpass_n_delay_config u_dut (
    .UserCLK(clk), .resetn(rst_n), .I(i_a), .CE(ce_a), .O(o_a), .ConfigBits(cfg_a));

  outpass_n_delay_config #(.NUM_CH(4), .MAX_DEPTH(2), .DW(2), .NoConfigBits(16)) u_dut2 (
    .UserCLK(clk), .resetn(rst_n), .I(i_b), .CE(ce_b), .O(o_b), .ConfigBits(cfg_b));

  outpass_n_delay_config #(.NUM_CH(8), .MAX_DEPTH(1), .DW(1), .NoConfigBits(24)) u_dut8 (
    .UserCLK(clk), .resetn(rst_n), .I(i_c), .CE(ce_c), .O(o_c), .ConfigBits(cfg_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Reference model for the random phase: inst 0 = default top, inst 1 = 8-channel/depth-1 top.
  bit ms [2][8][3];

  function automatic logic [7:0] model_out(input int inst, input logic [23:0] cfg, input logic [7:0] iv);
    int nch = (inst == 0) ? 4 : 8;
    int md  = (inst == 0) ? 3 : 1;
    int dw  = (inst == 0) ? 2 : 1;
    logic [7:0] o = '0;
    for (int c = 0; c < nch; c++) begin
      int base = c * (dw + 2);
      int dl = 0;
      int d;
      for (int b = 0; b < dw; b++) if (cfg[base+b]) dl += (1 << b);
      d = (dl > md) ? md : dl;
      o[c] = ((d == 0) ? iv[c] : ms[inst][c][d-1]) ^ cfg[base+dw+1];
    end
    return o;
  endfunction

  task automatic model_edge(input int inst, input logic [23:0] cfg, input logic [7:0] iv, input logic ce);
    int nch = (inst == 0) ? 4 : 8;
    int md  = (inst == 0) ? 3 : 1;
    int dw  = (inst == 0) ? 2 : 1;
    for (int c = 0; c < nch; c++) begin
      int base = c * (dw + 2);
      if (!cfg[base+dw] || ce) begin
        for (int k = md - 1; k > 0; k--) ms[inst][c][k] = ms[inst][c][k-1];
        ms[inst][c][0] = iv[c];
      end
    end
  endtask

  typedef struct {
    logic [15:0] cfg;
    logic [3:0]  i;
    logic [3:0]  exp;
  } byp_vec_t;

  byp_vec_t   tbl [5];
  logic [7:0] sb_q [$];
  logic [7:0] exp_v;

  initial begin
    tbl[0] = '{16'h0000, 4'b1010, 4'b1010};
    tbl[1] = '{16'h0000, 4'b0101, 4'b0101};
    tbl[2] = '{16'h8888, 4'b1010, 4'b0101};
    tbl[3] = '{16'h0080, 4'b0000, 4'b0010};
    tbl[4] = '{16'h4444, 4'b1111, 4'b1111};

    rst_n = 1'b0;
    cfg_a = '0; i_a = '0; ce_a = 1'b0;
    cfg_b = 16'h0B00; i_b = '0; ce_b = 1'b0;
    cfg_c = '0; i_c = '0; ce_c = 1'b0;
    #1;
    check("reset_o", 8'(o_a), 8'h00);
    check("reset_inv_clamp", 8'(o_b), 8'h04);
    @(negedge clk);
    rst_n = 1'b1;

    // Depth-0 channels: combinational, CE ignored, clock has no effect.
    for (int t = 0; t < 5; t++) begin
      cfg_a = tbl[t].cfg;
      i_a   = tbl[t].i;
      ce_a  = 1'b0;
      #1;
      check($sformatf("bypass%0d", t), 8'(o_a), 8'(tbl[t].exp));
      @(posedge clk);
      @(posedge clk);
      #1;
      check($sformatf("bypass_clk%0d", t), 8'(o_a), 8'(tbl[t].exp));
      @(negedge clk);
    end

    // ch0 delay 2: single-cycle pulse appears after exactly two edges.
    cfg_a = 16'h0002; i_a = '0; ce_a = 1'b0;
    pulse_reset();
    i_a = 4'b0001;
    @(negedge clk); i_a = '0; #1;
    check("delay2_e1", 8'(o_a), 8'h00);
    @(negedge clk); #1;
    check("delay2_e2", 8'(o_a), 8'h01);
    @(negedge clk); #1;
    check("delay2_e3", 8'(o_a), 8'h00);

    // ch1 delay 1 with CE gating.
    cfg_a = 16'h0050; i_a = '0; ce_a = 1'b0;
    pulse_reset();
    i_a = 4'b0010;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk); #1;
      check($sformatf("ce_blocked%0d", n), 8'(o_a[1]), 8'h00);
    end
    ce_a = 1'b1;
    @(negedge clk);
    ce_a = 1'b0; i_a = '0; #1;
    check("ce_capture", 8'(o_a), 8'h02);
    @(negedge clk); #1;
    check("ce_hold", 8'(o_a), 8'h02);

    // ch2 of the depth-2 instance: DELAY=3 clamps to 2, inverted output.
    @(negedge clk);
    rst_n = 1'b0; #1;
    check("clamp_in_reset", 8'(o_b), 8'h04);
    #1;
    rst_n = 1'b1;
    i_b = 4'b0100;
    @(negedge clk); i_b = '0; #1;
    check("clamp_e1", 8'(o_b), 8'h04);
    @(negedge clk); #1;
    check("clamp_e2", 8'(o_b), 8'h00);
    @(negedge clk); #1;
    check("clamp_e3", 8'(o_b), 8'h04);

    // ch3 delay 3: async reset between edges clears a full chain.
    cfg_a = 16'h3000; i_a = '0;
    pulse_reset();
    i_a = 4'b1000;
    repeat (3) @(negedge clk);
    #1;
    check("full_chain", 8'(o_a), 8'h08);
    #1;
    rst_n = 1'b0; #1;
    check("async_reset", 8'(o_a), 8'h00);
    @(negedge clk);
    rst_n = 1'b1; #1;
    check("post_rst_e0", 8'(o_a), 8'h00);
    @(negedge clk); #1;
    check("post_rst_e1", 8'(o_a), 8'h00);
    @(negedge clk); #1;
    check("post_rst_e2", 8'(o_a), 8'h00);
    @(negedge clk); #1;
    check("post_rst_e3", 8'(o_a), 8'h08);

    // Randomized run of the default and 8-channel instances against the model.
    @(negedge clk);
    rst_n = 1'b0;
    for (int a = 0; a < 2; a++)
      for (int c = 0; c < 8; c++)
        for (int k = 0; k < 3; k++) ms[a][c][k] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if (n % 250 == 0) begin
        cfg_a = 16'($urandom);
        cfg_c = 24'($urandom);
      end
      i_a  = 4'($urandom);
      ce_a = 1'($urandom);
      i_c  = 8'($urandom);
      ce_c = 1'($urandom);
      sb_q.push_back(model_out(0, 24'(cfg_a), 8'(i_a)));
      sb_q.push_back(model_out(1, cfg_c, i_c));
      #1;
      exp_v = sb_q.pop_front();
      check("rand_default", 8'(o_a), exp_v);
      exp_v = sb_q.pop_front();
      check("rand_ch8", o_c, exp_v);
      model_edge(0, 24'(cfg_a), 8'(i_a), ce_a);
      model_edge(1, cfg_c, i_c, ce_c);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
